uart_mem_loader: RTL and testbench

- Byte-stream loader between the spart receive path and memory port B.
- Parses a framed download from the host: sync byte, start word address, word count, payload, entry PC.
- Packs each 8 payload bytes into a 64-bit word and writes it into the unified memory through enb/web/addrb/dinb.
- At the end of a frame, hands the CPU a start PC through extern_pc/extern_pc_en.

---
 rtl/uart_mem_loader.sv | 180 ++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// UART framed-download loader: sync, address, count, 64-bit payload words, entry PC.
// Optional trailing XOR checksum byte enabled by UART_MEM_LOADER_CHECKSUM_EN.
module uart_mem_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned ADDR_W         = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              enb,
  output logic              web,
  output logic [ADDR_W-1:0] addrb,
  output logic [63:0]       dinb,
  output logic [15:0]       extern_pc,
  output logic              extern_pc_en,
  output logic              busy,
  output logic              err,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR_HI = 4'd1,
    ADDR_LO = 4'd2,
    CNT_HI  = 4'd3,
    CNT_LO  = 4'd4,
    DATA    = 4'd5,
    PC_HI   = 4'd6,
    PC_LO   = 4'd7,
    CSUM    = 4'd8,
    DONE    = 4'd9
  } state_t;

  localparam logic [31:0] GAP_TERM = 32'(TIMEOUT_CYCLES - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        hi_q;
  logic [15:0]       cnt_q;
  logic [15:0]       words_q;
  logic [2:0]        byte_cnt_q;
  logic [55:0]       asm_q;
  logic [63:0]       dinb_q;
  logic              enb_q;
  logic [15:0]       pc_q;
  logic              pc_en_q;
  logic              err_q;
  logic [31:0]       gap_q;
  logic [15:0]       cnt_d;
  logic              timeout_d;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
  logic [15:0]       pc_shadow_q;
`endif

  always_comb begin
    cnt_d     = {hi_q, rx_data};
    timeout_d = (state_q != IDLE) && !rx_valid && (gap_q == GAP_TERM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      hi_q       <= '0;
      cnt_q      <= '0;
      words_q    <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      dinb_q     <= '0;
      enb_q      <= 1'b0;
      pc_q       <= '0;
      pc_en_q    <= 1'b0;
      err_q      <= 1'b0;
      gap_q      <= '0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
      pc_shadow_q <= '0;
`endif
    end else begin
      enb_q   <= 1'b0;
      pc_en_q <= 1'b0;
      if (enb_q) addr_q <= addr_q + 1'b1;
      if (state_q == IDLE || rx_valid) gap_q <= '0;
      else                             gap_q <= gap_q + 1'b1;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      if (rx_valid && state_q >= ADDR_HI && state_q <= PC_LO) csum_q <= csum_q ^ rx_data;
`endif
      if (timeout_d) begin
        err_q   <= 1'b1;
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
            err_q      <= 1'b0;
            byte_cnt_q <= '0;
            words_q    <= '0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
            state_q    <= ADDR_HI;
          end
          ADDR_HI: if (rx_valid) begin
            hi_q    <= rx_data;
            state_q <= ADDR_LO;
          end
          ADDR_LO: if (rx_valid) begin
            addr_q  <= ADDR_W'(cnt_d);
            state_q <= CNT_HI;
          end
          CNT_HI: if (rx_valid) begin
            hi_q    <= rx_data;
            state_q <= CNT_LO;
          end
          CNT_LO: if (rx_valid) begin
            cnt_q   <= cnt_d;
            state_q <= (cnt_d == 16'd0) ? PC_HI : DATA;
          end
          DATA: if (rx_valid) begin
            asm_q      <= {asm_q[47:0], rx_data};
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (byte_cnt_q == 3'd7) begin
              dinb_q  <= {asm_q, rx_data};
              enb_q   <= 1'b1;
              words_q <= words_q + 1'b1;
              // Leave DATA as the last word completes; the pulse still fires next
              // cycle, so a PC byte arriving back-to-back with it is not lost.
              if (words_q + 16'd1 == cnt_q) state_q <= PC_HI;
            end
          end
          PC_HI: if (rx_valid) begin
            hi_q    <= rx_data;
            state_q <= PC_LO;
          end
          PC_LO: if (rx_valid) begin
`ifdef UART_MEM_LOADER_CHECKSUM_EN
            pc_shadow_q <= cnt_d;
            state_q     <= CSUM;
`else
            pc_q    <= cnt_d;
            pc_en_q <= 1'b1;
            state_q <= DONE;
`endif
          end
          CSUM: begin
`ifdef UART_MEM_LOADER_CHECKSUM_EN
            if (rx_valid) begin
              if (rx_data == csum_q) begin
                pc_q    <= pc_shadow_q;
                pc_en_q <= 1'b1;
                state_q <= DONE;
              end else begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            end
`else
            state_q <= IDLE;
`endif
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign enb          = enb_q;
  assign web          = enb_q;
  assign addrb        = addr_q;
  assign dinb         = dinb_q;
  assign extern_pc    = pc_q;
  assign extern_pc_en = pc_en_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;
  assign state        = state_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader; define UART_MEM_LOADER_CHECKSUM_EN for the checksum variant.
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        enb, web;
  logic [13:0] addrb;
  logic [63:0] dinb;
  logic [15:0] extern_pc;
  logic        extern_pc_en, busy, err;
  logic [3:0]  state;

  int checks = 0;
  int failures = 0;

  int          wr_total = 0;
  int          pcen_total = 0;
  int          web_bad = 0;
  logic [13:0] wr_addr [32];
  logic [63:0] wr_data [32];
  int          wb, pb;

  uart_mem_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100), .ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .extern_pc(extern_pc), .extern_pc_en(extern_pc_en),
    .busy(busy), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (enb) begin
      wr_addr[wr_total % 32] <= addrb;
      wr_data[wr_total % 32] <= dinb;
      wr_total <= wr_total + 1;
    end
    if (enb !== web) web_bad <= web_bad + 1;
    if (extern_pc_en) pcen_total <= pcen_total + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
  endtask

  task automatic gap(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sb(input logic [7:0] b, input bit bb);
    put(b);
    if (!bb) gap(1);
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] n, input logic [63:0] w0,
                       input logic [63:0] w1, input logic [15:0] pc, input bit bb, input bit bad);
    logic [7:0]  x;
    logic [63:0] w;
    logic [7:0]  b [6];
    x = 8'h00;
    sb(8'hA5, bb);
    b[0] = a[15:8]; b[1] = a[7:0]; b[2] = n[15:8]; b[3] = n[7:0];
    for (int i = 0; i < 4; i++) begin x ^= b[i]; sb(b[i], bb); end
    for (int i = 0; i < int'(n) && i < 2; i++) begin
      w = (i == 0) ? w0 : w1;
      for (int j = 7; j >= 0; j--) begin x ^= w[j*8 +: 8]; sb(w[j*8 +: 8], bb); end
    end
    b[4] = pc[15:8]; b[5] = pc[7:0];
    for (int i = 4; i < 6; i++) begin x ^= b[i]; sb(b[i], bb); end
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    sb(bad ? ~x : x, bb);
`endif
    gap(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk); #1;
    chk("rst_enb", {63'd0, enb}, 64'd0);
    chk("rst_addrb", 64'(addrb), 64'd0);
    chk("rst_dinb", dinb, 64'd0);
    chk("rst_pc", 64'(extern_pc), 64'd0);
    chk("rst_flags", {61'd0, extern_pc_en, busy, err}, 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    rst = 1'b0;
    gap(2);

    // single-word frame, with stray bytes in IDLE first
    sb(8'h00, 0); sb(8'h5A, 0);
    chk("idle_ignore", {63'd0, busy}, 64'd0);
    wb = wr_total; pb = pcen_total;
    frame(16'h0010, 16'd1, 64'h1122334455667788, 64'd0, 16'h0100, 0, 0);
    gap(5);
    chk("t1_nwr", 64'(wr_total - wb), 64'd1);
    chk("t1_addr", 64'(wr_addr[wb % 32]), 64'h0010);
    chk("t1_data", wr_data[wb % 32], 64'h1122334455667788);
    chk("t1_pcen", 64'(pcen_total - pb), 64'd1);
    chk("t1_pc", 64'(extern_pc), 64'h0100);
    chk("t1_err", {63'd0, err}, 64'd0);
    chk("t1_idle", 64'(state), 64'd0);

    // wrap, back-to-back bytes, sync byte inside payload
    wb = wr_total; pb = pcen_total;
    frame(16'h3FFF, 16'd2, 64'h0F1E2D3C4B5A6978, 64'hA5A5010203040506, 16'hBEEF, 1, 0);
    gap(5);
    chk("t2_nwr", 64'(wr_total - wb), 64'd2);
    chk("t2_addr0", 64'(wr_addr[wb % 32]), 64'h3FFF);
    chk("t2_addr1", 64'(wr_addr[(wb + 1) % 32]), 64'h0000);
    chk("t2_data0", wr_data[wb % 32], 64'h0F1E2D3C4B5A6978);
    chk("t2_data1", wr_data[(wb + 1) % 32], 64'hA5A5010203040506);
    chk("t2_pc", 64'(extern_pc), 64'hBEEF);
    chk("t2_pcen", 64'(pcen_total - pb), 64'd1);
    chk("t2_addr_after", 64'(addrb), 64'h0001);

    // zero-count frame
    wb = wr_total; pb = pcen_total;
    frame(16'h0000, 16'd0, 64'd0, 64'd0, 16'h1234, 0, 0);
    gap(5);
    chk("t3_nwr", 64'(wr_total - wb), 64'd0);
    chk("t3_pc", 64'(extern_pc), 64'h1234);
    chk("t3_pcen", 64'(pcen_total - pb), 64'd1);

    // timeout after 3 of 8 data bytes
    wb = wr_total; pb = pcen_total;
    sb(8'hA5, 0); sb(8'h02, 0); sb(8'h00, 0); sb(8'h00, 0); sb(8'h01, 0);
    sb(8'h11, 0); sb(8'h22, 0); put(8'h33);
    gap(90);
    chk("t4_busy_pre", {62'd0, busy, err}, 64'd2);
    gap(20);
    chk("t4_err", {63'd0, err}, 64'd1);
    chk("t4_busy", {63'd0, busy}, 64'd0);
    chk("t4_pcen", 64'(pcen_total - pb), 64'd0);
    chk("t4_pc_held", 64'(extern_pc), 64'h1234);
    chk("t4_nwr", 64'(wr_total - wb), 64'd0);
    wb = wr_total; pb = pcen_total;
    frame(16'h0400, 16'd1, 64'h0123456789ABCDEF, 64'd0, 16'h2000, 0, 0);
    gap(5);
    chk("t4b_err", {63'd0, err}, 64'd0);
    chk("t4b_data", wr_data[wb % 32], 64'h0123456789ABCDEF);
    chk("t4b_addr", 64'(wr_addr[wb % 32]), 64'h0400);
    chk("t4b_pcen", 64'(pcen_total - pb), 64'd1);

    // asynchronous reset after 5 data bytes
    sb(8'hA5, 0); sb(8'h03, 0); sb(8'h00, 0); sb(8'h00, 0); sb(8'h01, 0);
    for (int i = 0; i < 5; i++) sb(8'h70 + 8'(i), 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_state", 64'(state), 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_dinb", dinb, 64'd0);
    chk("t5_pc", 64'(extern_pc), 64'd0);
    chk("t5_addrb", 64'(addrb), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    gap(2);
    wb = wr_total; pb = pcen_total;
    frame(16'h0500, 16'd1, 64'hDEADBEEFCAFEF00D, 64'd0, 16'h3000, 0, 0);
    gap(5);
    chk("t5b_nwr", 64'(wr_total - wb), 64'd1);
    chk("t5b_data", wr_data[wb % 32], 64'hDEADBEEFCAFEF00D);
    chk("t5b_addr", 64'(wr_addr[wb % 32]), 64'h0500);
    chk("t5b_pc", 64'(extern_pc), 64'h3000);
    chk("t5b_pcen", 64'(pcen_total - pb), 64'd1);

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    wb = wr_total; pb = pcen_total;
    frame(16'h0600, 16'd1, 64'h8877665544332211, 64'd0, 16'h4000, 0, 1);
    gap(5);
    chk("cs_bad_err", {63'd0, err}, 64'd1);
    chk("cs_bad_pcen", 64'(pcen_total - pb), 64'd0);
    chk("cs_bad_nwr", 64'(wr_total - wb), 64'd1);
    chk("cs_bad_pc", 64'(extern_pc), 64'h3000);
    pb = pcen_total;
    frame(16'h0600, 16'd1, 64'h8877665544332211, 64'd0, 16'h4000, 0, 0);
    gap(5);
    chk("cs_ok_err", {63'd0, err}, 64'd0);
    chk("cs_ok_pcen", 64'(pcen_total - pb), 64'd1);
    chk("cs_ok_pc", 64'(extern_pc), 64'h4000);
`endif

    chk("web_tracks_enb", 64'(web_bad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
